// File: rtl/ram32_sp_fifo_pkg.sv
// Shared constants and the per-cycle operation encoding for the
// single-port LUT-RAM FIFO.
package ram32_sp_fifo_pkg;

  localparam int DEPTH = 32;
  localparam int PTR_W = 5;
  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_REFILL,
    OP_BYPASS,
    OP_WRITE,
    OP_DRAIN
  } op_t;

endpackage

// File: rtl/RAM32X1S.sv
// Behavioural model of a 32x1 single-port distributed RAM:
// asynchronous read, synchronous write on the (optionally inverted) WCLK.
module RAM32X1S #(
  parameter logic [31:0] INIT             = 32'h0,
  parameter logic [0:0]  IS_WCLK_INVERTED = 1'b0
) (
  output logic O,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  input  logic D,
  input  logic WCLK,
  input  logic WE
);

  logic [4:0]  addr;
  logic        wclk_eff;
  logic [31:0] mem_q = INIT;

  assign addr     = {A4, A3, A2, A1, A0};
  assign wclk_eff = WCLK ^ IS_WCLK_INVERTED;

  always_ff @(posedge wclk_eff) begin
    if (WE) mem_q[addr] <= D;
  end

  assign O = mem_q[addr];

endmodule

// File: rtl/ram32_sp_bank.sv
// WIDTH-bit storage built from one 32x1 RAM per bit, all bits sharing
// one address and write enable.
module ram32_sp_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [4:0]       addr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    RAM32X1S #(
      .INIT             (32'h0),
      .IS_WCLK_INVERTED (1'b0)
    ) u_ram (
      .O    (dout_o[gi]),
      .A0   (addr_i[0]),
      .A1   (addr_i[1]),
      .A2   (addr_i[2]),
      .A3   (addr_i[3]),
      .A4   (addr_i[4]),
      .D    (din_i[gi]),
      .WCLK (clk_i),
      .WE   (we_i)
    );
  end

endmodule

// File: rtl/ram32_sp_fifo.sv
// First-word-fall-through FIFO: the single RAM port is shared between
// push writes and head refills, and the head word lives in DOUT.
module ram32_sp_fifo
  import ram32_sp_fifo_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT_DOUT = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] DOUT,
  output logic [5:0]       LEVEL
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             take, refill, push, ram_we;
  logic [PTR_W-1:0] ram_addr;
  logic [WIDTH-1:0] ram_dout;
  op_t              op;

  // Refill owns the port whenever the head register frees up and RAM has data;
  // this stall is what keeps bypass from overtaking words still in RAM.
  assign take     = !out_valid_q || OUT_READY;
  assign refill   = take && (mem_cnt_q != '0);
  assign IN_READY = !refill && ((mem_cnt_q != FULL_CNT) || take);
  assign push     = IN_VALID && IN_READY;

  always_comb begin
    op = OP_IDLE;
    if (refill)          op = OP_REFILL;
    else if (push && take) op = OP_BYPASS;
    else if (push)       op = OP_WRITE;
    else if (take)       op = OP_DRAIN;
  end

  assign ram_we   = (op == OP_WRITE) && !RST;
  assign ram_addr = ram_we ? wr_ptr_q : rd_ptr_q;

  ram32_sp_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk_i  (CLK),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .din_i  (DIN),
    .dout_o (ram_dout)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    case (op)
      OP_REFILL: begin
        dout_d      = ram_dout;
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + 1'b1;
        mem_cnt_d   = mem_cnt_q - 1'b1;
      end
      OP_BYPASS: begin
        dout_d      = DIN;
        out_valid_d = 1'b1;
      end
      OP_WRITE: begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        mem_cnt_d = mem_cnt_q + 1'b1;
      end
      OP_DRAIN: out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= INIT_DOUT;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign DOUT      = dout_q;
  assign LEVEL     = mem_cnt_q + {{(CNT_W-1){1'b0}}, out_valid_q};

endmodule

// File: tb/tb_ram32_sp_fifo.sv
// Directed vector table plus hand-written fill, wrap, refill-priority and
// reset sequences for the single-port LUT-RAM FIFO.
module tb_ram32_sp_fifo;

  localparam logic [7:0] INIT_V = 8'h5A;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] DIN = 8'h00;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] DOUT;
  logic [5:0] LEVEL;

  int n_tests = 0;
  int n_fail  = 0;

  ram32_sp_fifo #(
    .WIDTH     (8),
    .INIT_DOUT (INIT_V)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DIN       (DIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .DOUT      (DOUT),
    .LEVEL     (LEVEL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_dout;
    logic [5:0] exp_lvl;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // Inputs are set 1 time unit after an edge; combinational IN_READY is read
  // 1 unit later, registered outputs 1 unit after the following edge.
  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
    IN_VALID = iv; DIN = d; OUT_READY = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  initial begin
    // iv din ordy | in_ready | ov dout level (after edge)
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 6'd1};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'hA5, 6'd2};
    vecs[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'hA5, 6'd3};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 6'd2};
    vecs[4]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 6'd1};
    vecs[5]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 6'd1};
    vecs[6]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44, 6'd1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44, 6'd0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h44, 6'd0};
    vecs[9]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 6'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 6'd1};

    // Reset state
    @(posedge CLK); #1;
    do_reset();
    drive(1'b0, 8'h00, 1'b0);
    chk("rst_out_valid", int'(OUT_VALID), 0);
    chk("rst_dout", int'(DOUT), int'(INIT_V));
    chk("rst_level", int'(LEVEL), 0);
    chk("rst_in_ready", int'(IN_READY), 1);
    $display("[TB] reset: ov=%0d dout=%02h level=%0d rdy=%0d", OUT_VALID, DOUT, LEVEL, IN_READY);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].iv, vecs[i].din, vecs[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), int'(IN_READY), int'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), int'(OUT_VALID), int'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_dout", i), int'(DOUT), int'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_level", i), int'(LEVEL), int'(vecs[i].exp_lvl));
      $display("[TB] vec %0d: iv=%0d din=%02h ordy=%0d -> ov=%0d dout=%02h level=%0d",
               i, vecs[i].iv, vecs[i].din, vecs[i].ordy, OUT_VALID, DOUT, LEVEL);
    end

    // Fill to 33 words, then drain in order
    do_reset();
    for (int k = 0; k < 33; k++) begin
      drive(1'b1, 8'(k), 1'b0);
      chk($sformatf("fill%0d_in_ready", k), int'(IN_READY), 1);
      tick();
    end
    drive(1'b1, 8'hEE, 1'b0);
    $display("[TB] fill: level=%0d rdy=%0d dout=%02h", LEVEL, IN_READY, DOUT);
    chk("fill_level", int'(LEVEL), 33);
    chk("fill_in_ready", int'(IN_READY), 0);
    chk("fill_head", int'(DOUT), 0);
    tick();
    chk("fill_hold_level", int'(LEVEL), 33);
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 33; k++) begin
      chk($sformatf("drain%0d_out_valid", k), int'(OUT_VALID), 1);
      chk($sformatf("drain%0d_dout", k), int'(DOUT), k);
      chk($sformatf("drain%0d_level", k), int'(LEVEL), 33 - k);
      $display("[TB] drain %0d: dout=%02h level=%0d", k, DOUT, LEVEL);
      tick();
    end
    chk("drain_out_valid", int'(OUT_VALID), 0);
    chk("drain_level", int'(LEVEL), 0);

    // Wrap: 80 words through with random stalls, checked against a queue
    begin
      logic [7:0] q[$];
      logic [7:0] exp_w;
      int pushed = 0;
      int popped = 0;
      int cyc = 0;
      while (popped < 80 && cyc < 3000) begin
        logic iv, ordy;
        if (pushed < 40) begin
          iv   = ($urandom_range(3) != 0);
          ordy = ($urandom_range(3) == 0);
        end else begin
          iv   = (pushed < 80) && ($urandom_range(1) == 0);
          ordy = ($urandom_range(3) != 0);
        end
        drive(iv, 8'(pushed + 8'h80), ordy);
        chk("wrap_level", int'(LEVEL), q.size());
        if (OUT_VALID && OUT_READY) begin
          if (q.size() == 0) begin
            chk("wrap_underflow", 1, 0);
          end else begin
            exp_w = q.pop_front();
            chk($sformatf("wrap_word%0d", popped), int'(DOUT), int'(exp_w));
          end
          $display("[TB] wrap pop %0d: dout=%02h", popped, DOUT);
          popped++;
        end
        if (IN_VALID && IN_READY) begin
          q.push_back(DIN);
          pushed++;
        end
        tick();
        cyc++;
      end
      chk("wrap_all_popped", popped, 80);
    end

    // Refill priority: LEVEL=5 then consume with producer waiting
    drive(1'b0, 8'h00, 1'b0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(8'h60 + k), 1'b0);
      tick();
    end
    chk("prio_level", int'(LEVEL), 5);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'hC0, 1'b1);
      chk($sformatf("prio_stall%0d", k), int'(IN_READY), 0);
      tick();
      chk($sformatf("prio_dout%0d", k), int'(DOUT), 8'h61 + k);
      $display("[TB] prio %0d: rdy=0 dout=%02h level=%0d", k, DOUT, LEVEL);
    end
    drive(1'b1, 8'hC0, 1'b1);
    chk("prio_resume", int'(IN_READY), 1);
    tick();
    chk("prio_bypass_dout", int'(DOUT), 8'hC0);
    chk("prio_bypass_level", int'(LEVEL), 1);

    // Reset mid-operation at LEVEL=10
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'(8'h10 + k), 1'b0);
      tick();
    end
    chk("mid_level_pre", int'(LEVEL), 10);
    RST = 1'b1;
    drive(1'b1, 8'h77, 1'b0);
    tick();
    RST = 1'b0;
    chk("mid_rst_out_valid", int'(OUT_VALID), 0);
    chk("mid_rst_level", int'(LEVEL), 0);
    chk("mid_rst_dout", int'(DOUT), int'(INIT_V));
    drive(1'b1, 8'h3C, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("mid_first_word", int'(DOUT), 8'h3C);
    chk("mid_first_valid", int'(OUT_VALID), 1);
    chk("mid_first_level", int'(LEVEL), 1);
    $display("[TB] mid reset: dout=%02h level=%0d", DOUT, LEVEL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram32_sp_fifo.md
# ram32_sp_fifo

First-word-fall-through FIFO controller built on a WIDTH-bit bank of 32x1 single-port distributed RAM, one RAM32X1S per data bit, all sharing one address and write enable. It arbitrates the single shared port between push and prefetch, and holds the head word in an output register. It sits between a valid/ready producer and consumer wherever a shallow LUT-RAM buffer is cheaper than block RAM. It is Verilator-compatible like the rest of the primitive library.

## Interface
- WIDTH, 8: data width; one 32x1 RAM per bit.
- INIT_DOUT, {WIDTH{1'b0}}: reset value of DOUT.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  producer has a word on DIN.
- IN_READY  out  1  FIFO accepts DIN this cycle.
- DIN  in  WIDTH  write data.
- OUT_VALID  out  1  DOUT holds the head word.
- OUT_READY  in  1  consumer takes DOUT this cycle.
- DOUT  out  WIDTH  head word, registered.
- LEVEL  out  6  total occupancy 0..33 (RAM count plus OUT_VALID).

## Operation
- State registers:
  - wr_ptr[4:0] and rd_ptr[4:0]: wrap modulo 32 naturally.
  - mem_cnt[5:0]: 0..32 words held in RAM.
  - OUT_VALID and DOUT.
- Control signals:
  - take = !OUT_VALID || OUT_READY (output register free at the next edge).
  - refill = take && mem_cnt != 0.
  - IN_READY = !refill && (mem_cnt != 32 || take).
  - push = IN_VALID && IN_READY.
- Per cycle, exactly one of the following applies:
  - REFILL (refill=1): address=rd_ptr, WE=0. DOUT<=RAM out, OUT_VALID<=1, rd_ptr++, mem_cnt--. The producer is stalled.
  - BYPASS (!refill, take, mem_cnt==0, push): DIN goes directly to DOUT and OUT_VALID<=1. The RAM is untouched.
  - WRITE (!refill, !take, push): address=wr_ptr, WE=1, data=DIN, wr_ptr++, mem_cnt++.
  - DRAIN (take, no refill, no push): OUT_VALID<=0. DOUT keeps its last value.
  - IDLE: no change.
- When mem_cnt==32 and the output register is full and held, IN_READY=0. The next consume triggers REFILL, not a write.
- Storage address mux is combinational: WE ? wr_ptr : rd_ptr. Read data is asynchronous and is sampled into DOUT at the edge.
- LEVEL = mem_cnt + OUT_VALID, computed at 6-bit width with no overflow (maximum 33).
- Data order is strictly FIFO across BYPASS/WRITE/REFILL. BYPASS is only legal when the RAM is empty, which guarantees this.

## Timing
- Reset values: OUT_VALID=0, DOUT=INIT_DOUT, LEVEL=0, pointers=0, mem_cnt=0, IN_READY=1 (first cycle after reset). RAM contents are not reset, so stale data is unreachable.
- RST asserted mid-transfer discards all words on that edge. WE is forced 0 while RST=1.
- Latency: a push into an empty FIFO appears as OUT_VALID=1 on the next cycle.
- Throughput: bypass streaming runs 1 word/cycle. While mem_cnt>0 and the consumer is ready every cycle, refills block pushes, so the RAM drains at 1/cycle before input resumes. This single-port limitation is accepted.
- OUT_VALID/DOUT are stable while OUT_VALID && !OUT_READY.
- IN_READY depends combinationally on OUT_READY. There is no path from IN_VALID to IN_READY.

## Structure
- Package ram32_sp_fifo_pkg holds:
  - DEPTH=32, PTR_W=5, CNT_W=6.
  - The op enum {OP_IDLE, OP_REFILL, OP_BYPASS, OP_WRITE, OP_DRAIN}.
- Sub-module ram32_sp_bank: a generate loop of WIDTH RAM32X1S instances (INIT=0, IS_WCLK_INVERTED=0) with shared A0..A4/WE/WCLK=CLK. It exposes a WIDTH-bit D/O.
- The controller (pointers, counter, output register, op decode) lives in the top module.

## Test plan
- Reset then single push of 0xA5 with OUT_READY=0:
  - Cycle+1: OUT_VALID=1, DOUT=0xA5, LEVEL=1, no RAM write.
- Fill: OUT_READY=0, push 0x00..0x20 (33 words):
  - LEVEL reaches 33 and IN_READY=0 after the 33rd.
  - Then OUT_READY=1 drains 0x00..0x20 in order, each refill taking one cycle. LEVEL returns to 0.
- Wrap: repeat push 40/pop 40 interleaved with random stalls.
  - Pointers wrap past 31.
  - The scoreboard sees all 80 words in order.
- Refill priority: LEVEL=5, OUT_VALID=1, OUT_READY=1, IN_VALID=1:
  - IN_READY=0 for 4 consecutive cycles (RAM drains).
  - On the 5th cycle IN_READY=1 and bypass resumes.
- Reset mid-operation: LEVEL=10, assert RST one cycle with IN_VALID=1:
  - Next cycle OUT_VALID=0, LEVEL=0, DOUT=INIT_DOUT.
  - A subsequent push of 0x3C is the first word out.
- Simultaneous push/pop at LEVEL=1 with RAM empty:
  - Bypass replaces DOUT with the new word the following cycle.
  - LEVEL stays 1.
